alu_operand_stage: RTL and testbench

- Pipeline stage directly upstream of the ALU.
- Accepts decoded instructions and reads source operands from an internal register file, bypassing same-cycle writeback.
- Stalls on read-after-write hazards using a pending-write scoreboard.
- Presents registered X, Y and ALUop (plus destination tag) to the ALU through a valid/ready output register; writeback feeds results back through a write port.

---
 rtl/alu_operand_stage_pkg.sv | 14 +
 rtl/alu_operand_stage_regfile.sv | 37 +++
 rtl/alu_operand_stage.sv | 106 ++++++++++
 tb/tb_alu_operand_stage.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/alu_operand_stage_pkg.sv
// alu_operand_stage_pkg: shared word/register/ALUop widths and ALUop encodings
package alu_operand_stage_pkg;
    localparam int WORD   = 16;
    localparam int REGNUM = 4;
    localparam int ALUOP  = 3;
    localparam logic [ALUOP-1:0] ALU_ADD = 3'd0;
    localparam logic [ALUOP-1:0] ALU_SUB = 3'd1;
    localparam logic [ALUOP-1:0] ALU_AND = 3'd2;
    localparam logic [ALUOP-1:0] ALU_OR  = 3'd3;
    localparam logic [ALUOP-1:0] ALU_XOR = 3'd4;
    localparam logic [ALUOP-1:0] ALU_SLT = 3'd5;
    localparam logic [ALUOP-1:0] ALU_SLL = 3'd6;
    localparam logic [ALUOP-1:0] ALU_SRL = 3'd7;
endpackage

// File: rtl/alu_operand_stage_regfile.sv
// alu_operand_stage_regfile: register array with one write port and two write-through read ports
// Ports: clk/reset_n, we/waddr/wdata write port, raddr_a/rdata_a and raddr_b/rdata_b combinational reads
module alu_operand_stage_regfile
    import alu_operand_stage_pkg::*;
#(
    parameter int WIDTH   = WORD,
    parameter int REGBITS = REGNUM
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               we,
    input  logic [REGBITS-1:0] waddr,
    input  logic [WIDTH-1:0]   wdata,
    input  logic [REGBITS-1:0] raddr_a,
    output logic [WIDTH-1:0]   rdata_a,
    input  logic [REGBITS-1:0] raddr_b,
    output logic [WIDTH-1:0]   rdata_b
);
    localparam int NREG = 1 << REGBITS;

    logic [WIDTH-1:0] mem_q [NREG];
    logic [WIDTH-1:0] mem_d [NREG];

    always_comb begin
        mem_d = mem_q;
        if (we) mem_d[waddr] = wdata;
    end

    // same-cycle writeback is forwarded so a reader never sees the stale value
    assign rdata_a = (we && waddr == raddr_a) ? wdata : mem_q[raddr_a];
    assign rdata_b = (we && waddr == raddr_b) ? wdata : mem_q[raddr_b];

    always_ff @(posedge clk) begin
        if (!reset_n) mem_q <= '{default: '0};
        else          mem_q <= mem_d;
    end
endmodule

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: operand fetch with RAW scoreboard and valid/ready output register feeding the ALU
// Ports: in_* decoded instruction handshake, wb_* writeback port, out_* registered ALU operands, stall_count hazard stall counter
module alu_operand_stage
    import alu_operand_stage_pkg::*;
#(
    parameter int WIDTH   = WORD,
    parameter int REGBITS = REGNUM,
    parameter int OPBITS  = ALUOP
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OPBITS-1:0]  in_op,
    input  logic [REGBITS-1:0] in_rs,
    input  logic [REGBITS-1:0] in_rt,
    input  logic [REGBITS-1:0] in_rd,
    input  logic               in_wr,
    input  logic               in_use_imm,
    input  logic [WIDTH-1:0]   in_imm,
    input  logic               wb_en,
    input  logic [REGBITS-1:0] wb_addr,
    input  logic [WIDTH-1:0]   wb_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_X,
    output logic [WIDTH-1:0]   out_Y,
    output logic [OPBITS-1:0]  out_ALUop,
    output logic [REGBITS-1:0] out_rd,
    output logic               out_wr,
    output logic [15:0]        stall_count
);
    localparam int NREG = 1 << REGBITS;

    logic [WIDTH-1:0]   rdata_a, rdata_b;
    logic [NREG-1:0]    pending_q, pending_d, wb_hot, set_hot;
    logic               valid_q, valid_d, wr_q, wr_d;
    logic [WIDTH-1:0]   x_q, x_d, y_q, y_d;
    logic [OPBITS-1:0]  op_q, op_d;
    logic [REGBITS-1:0] rd_q, rd_d;
    logic [15:0]        stall_q, stall_d;
    logic               rs_busy, rt_busy, hazard, space, accept;

    alu_operand_stage_regfile #(.WIDTH(WIDTH), .REGBITS(REGBITS)) u_regfile (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (wb_en),
        .waddr   (wb_addr),
        .wdata   (wb_data),
        .raddr_a (in_rs),
        .rdata_a (rdata_a),
        .raddr_b (in_rt),
        .rdata_b (rdata_b)
    );

    always_comb begin
        // a writeback landing this cycle resolves the hazard through the bypass
        rs_busy   = pending_q[in_rs] && !(wb_en && wb_addr == in_rs);
        rt_busy   = !in_use_imm && pending_q[in_rt] && !(wb_en && wb_addr == in_rt);
        hazard    = in_valid && (rs_busy || rt_busy);
        space     = !valid_q || out_ready;
        in_ready  = space && !hazard;
        accept    = in_valid && in_ready;
        wb_hot    = {{(NREG-1){1'b0}}, wb_en} << wb_addr;
        set_hot   = {{(NREG-1){1'b0}}, accept && in_wr} << in_rd;
        // set is applied after clear so a same-cycle issue to the written register stays pending
        pending_d = (pending_q & ~wb_hot) | set_hot;
        valid_d   = accept || (!space && valid_q);
        x_d       = accept ? rdata_a : x_q;
        y_d       = accept ? (in_use_imm ? in_imm : rdata_b) : y_q;
        op_d      = accept ? in_op : op_q;
        rd_d      = accept ? in_rd : rd_q;
        wr_d      = accept ? in_wr : wr_q;
        stall_d   = (in_valid && space && hazard && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pending_q <= '0;
            valid_q   <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            op_q      <= '0;
            rd_q      <= '0;
            wr_q      <= 1'b0;
            stall_q   <= '0;
        end else begin
            pending_q <= pending_d;
            valid_q   <= valid_d;
            x_q       <= x_d;
            y_q       <= y_d;
            op_q      <= op_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            stall_q   <= stall_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_X       = x_q;
    assign out_Y       = y_q;
    assign out_ALUop   = op_q;
    assign out_rd      = rd_q;
    assign out_wr      = wr_q;
    assign stall_count = stall_q;
endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage: directed and random stimulus against an instruction-level reference model
module tb_alu_operand_stage;
    import alu_operand_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n, in_valid, in_wr, in_use_imm, wb_en, out_ready;
    logic [2:0]  in_op;
    logic [3:0]  in_rs, in_rt, in_rd, wb_addr;
    logic [15:0] in_imm, wb_data;
    logic        in_ready, out_valid, out_wr;
    logic [15:0] out_X, out_Y, stall_count;
    logic [2:0]  out_ALUop;
    logic [3:0]  out_rd;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] m_reg [16];
    bit          m_pend [16];
    bit          m_ov, m_wr;
    logic [15:0] m_x, m_y;
    logic [2:0]  m_op;
    logic [3:0]  m_rd;
    int          m_stall;

    always #5 clk = ~clk;

    alu_operand_stage dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_wr(in_wr),
        .in_use_imm(in_use_imm), .in_imm(in_imm), .wb_en(wb_en), .wb_addr(wb_addr),
        .wb_data(wb_data), .out_valid(out_valid), .out_ready(out_ready), .out_X(out_X),
        .out_Y(out_Y), .out_ALUop(out_ALUop), .out_rd(out_rd), .out_wr(out_wr),
        .stall_count(stall_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit m_busy(input logic [3:0] r);
        return m_pend[r] && !(wb_en && wb_addr == r);
    endfunction

    function automatic logic [15:0] m_read(input logic [3:0] r);
        return (wb_en && wb_addr == r) ? wb_data : m_reg[r];
    endfunction

    function automatic bit m_space();
        return !m_ov || out_ready;
    endfunction

    function automatic bit m_hazard();
        return in_valid && (m_busy(in_rs) || (!in_use_imm && m_busy(in_rt)));
    endfunction

    function automatic bit m_ready();
        return m_space() && !m_hazard();
    endfunction

    // one instruction-level model step applied at the clock edge
    task automatic m_clock();
        bit acc;
        acc = in_valid && m_ready();
        if (!reset_n) begin
            foreach (m_reg[i]) begin m_reg[i] = 16'h0; m_pend[i] = 0; end
            m_ov = 0; m_x = 0; m_y = 0; m_op = 0; m_rd = 0; m_wr = 0; m_stall = 0;
        end else begin
            if (in_valid && m_space() && m_hazard() && m_stall < 65535) m_stall++;
            if (acc) begin
                m_ov = 1; m_x = m_read(in_rs); m_y = in_use_imm ? in_imm : m_read(in_rt);
                m_op = in_op; m_rd = in_rd; m_wr = in_wr;
            end else if (m_space()) m_ov = 0;
            if (wb_en) begin m_pend[wb_addr] = 0; m_reg[wb_addr] = wb_data; end
            if (acc && in_wr) m_pend[in_rd] = 1;
        end
    endtask

    task automatic step();
        #1;
        if (reset_n) chk("in_ready", {31'b0, in_ready}, {31'b0, m_ready()});
        @(posedge clk);
        m_clock();
        #1;
        chk("out_valid", {31'b0, out_valid}, {31'b0, m_ov});
        chk("out_X", {16'b0, out_X}, {16'b0, m_x});
        chk("out_Y", {16'b0, out_Y}, {16'b0, m_y});
        chk("out_ctl", {24'b0, out_ALUop, out_rd, out_wr}, {24'b0, m_op, m_rd, m_wr});
        chk("stall_count", {16'b0, stall_count}, m_stall[31:0]);
        @(negedge clk);
    endtask

    task automatic issue(input logic v, input logic [2:0] op, input logic [3:0] rs, input logic [3:0] rt,
                         input logic [3:0] rd, input logic wr, input logic ui, input logic [15:0] imm);
        in_valid = v; in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_wr = wr; in_use_imm = ui; in_imm = imm;
    endtask

    task automatic wb(input logic en, input logic [3:0] a, input logic [15:0] d);
        wb_en = en; wb_addr = a; wb_data = d;
    endtask

    initial begin
        reset_n = 0; out_ready = 1;
        issue(0, 0, 0, 0, 0, 0, 0, 0);
        wb(0, 0, 0);
        @(negedge clk);
        step();
        step();
        chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_stall", {16'b0, stall_count}, 32'd0);
        reset_n = 1;
        // register setup and a simple ADD
        wb(1, 1, 16'h0005); step();
        wb(1, 2, 16'h0003); step();
        wb(0, 0, 0);
        issue(1, ALU_ADD, 1, 2, 3, 0, 0, 0); step();
        chk("add_X", {16'b0, out_X}, 32'h5);
        chk("add_Y", {16'b0, out_Y}, 32'h3);
        chk("add_op_rd", {28'b0, out_ALUop, out_rd[0]}, {28'b0, ALU_ADD, 1'b1});
        // RAW hazard stalls until writeback, then bypass supplies the value
        issue(1, ALU_SUB, 1, 2, 3, 1, 0, 0); step();
        issue(1, ALU_AND, 3, 1, 6, 0, 0, 0);
        #1 chk("raw_stall_ready", {31'b0, in_ready}, 32'd0);
        step(); step();
        chk("raw_stall_count", {16'b0, stall_count}, 32'd2);
        wb(1, 3, 16'h0008);
        #1 chk("raw_bypass_ready", {31'b0, in_ready}, 32'd1);
        step();
        wb(0, 0, 0);
        chk("raw_bypass_X", {16'b0, out_X}, 32'h8);
        // immediate ignores a pending rt
        issue(1, ALU_OR, 1, 2, 3, 1, 0, 0); step();
        issue(1, ALU_XOR, 1, 3, 7, 0, 1, 16'hFFFF);
        #1 chk("imm_ready", {31'b0, in_ready}, 32'd1);
        step();
        chk("imm_Y", {16'b0, out_Y}, 32'hFFFF);
        // backpressure holds the output and is not counted as a stall
        out_ready = 0;
        issue(1, ALU_SLT, 2, 2, 8, 0, 0, 0);
        #1 chk("bp_ready", {31'b0, in_ready}, 32'd0);
        step(); step();
        chk("bp_hold_Y", {16'b0, out_Y}, 32'hFFFF);
        out_ready = 1; step();
        chk("bp_release_X", {16'b0, out_X}, 32'h3);
        // same-cycle issue and writeback to r4 leaves r4 pending
        wb(1, 4, 16'h0011);
        issue(1, ALU_SLL, 1, 2, 4, 1, 0, 0); step();
        wb(0, 0, 0);
        issue(1, ALU_SRL, 4, 1, 9, 0, 0, 0);
        #1 chk("set_wins_ready", {31'b0, in_ready}, 32'd0);
        step();
        // reset discards held output and pending state
        issue(1, ALU_ADD, 1, 2, 5, 1, 0, 0);
        wb(1, 4, 16'h0022); step();
        wb(0, 0, 0);
        reset_n = 0; out_ready = 0; step();
        chk("mid_reset_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_reset_stall", {16'b0, stall_count}, 32'd0);
        reset_n = 1; out_ready = 1;
        issue(1, ALU_ADD, 5, 1, 10, 0, 0, 0);
        #1 chk("post_reset_ready", {31'b0, in_ready}, 32'd1);
        step();
        chk("post_reset_X", {16'b0, out_X}, 32'h0);
        // random traffic
        for (int i = 0; i < 600; i++) begin
            reset_n = ($urandom_range(99) != 0);
            out_ready = ($urandom_range(4) != 0);
            issue($urandom_range(3) != 0, 3'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                  1'($urandom), $urandom_range(3) == 0, 16'($urandom));
            wb($urandom_range(1) == 1, 4'($urandom), 16'($urandom));
            step();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
